branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, number of direct-mapped entries (power of two, 4..256).
REQ-002 SHALL have parameter PC_WIDTH, default 32, width of the PC type.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port lookupPc, input, PC_WIDTH, fetch-stage PC to predict.
REQ-006 SHALL have port hit, output, 1, which is 1 when a valid, tag-matching entry predicts taken.
REQ-007 SHALL have port predictedNextPc, output, PC_WIDTH, which is the stored target when hit=1, else lookupPc+4.
REQ-008 SHALL have port ready, output, 1, which is 0 while the invalidation sweep runs.
REQ-009 SHALL have port updValid, input, 1, memory-access-stage isBranch (resolved branch present).
REQ-010 SHALL have port updPc, input, PC_WIDTH, PC of the resolved branch.
REQ-011 SHALL have port updTaken, input, 1, memory-access-stage branchTaken.
REQ-012 SHALL have port updTarget, input, PC_WIDTH, memory-access-stage irregPc (resolved target).

Function
REQ-013 SHALL index entries with pc[IDX+1:2], IDX=log2(ENTRIES), and tag with pc[PC_WIDTH-1:IDX+2]; pc[1:0] is ignored.
REQ-014 SHALL store per entry: valid, tag, target (PC_WIDTH), and a 2-bit saturating counter.
REQ-015 SHALL compute hit combinationally (zero-cycle latency) as ready & valid & tagMatch & counter[1].
REQ-016 SHALL have FSM states INIT and RUN; INIT clears valid[sweepIdx] each cycle, with sweepIdx running 0..ENTRIES-1, and SHALL then enter RUN; in INIT, ready=0 and hit=0.
REQ-017 SHALL ignore updates (no state change) while in INIT.
REQ-018 In RUN, when updValid & updTaken and the entry misses (invalid or tag mismatch), SHALL allocate it: valid=1, new tag, target=updTarget, counter=2'b10.
REQ-019 In RUN, when updValid & updTaken and the entry hits, SHALL set target=updTarget and saturate-increment the counter (max 2'b11).
REQ-020 In RUN, when updValid & !updTaken and the entry hits, SHALL saturate-decrement the counter (min 2'b00) and keep valid=1.
REQ-021 In RUN, when updValid & !updTaken and the entry misses, SHALL change no state.
REQ-022 When a lookup and an update hit the same index in the same cycle, lookup SHALL return the pre-edge contents (no bypass); the update SHALL be visible from the next cycle.
REQ-023 SHALL compute lookupPc+4 modulo 2^PC_WIDTH (wraps to 0).
REQ-024 SHALL ignore updValid when it is 0, regardless of the other update inputs.

Reset
REQ-025 Asserting rst in any cycle SHALL on the next edge set state=INIT and sweepIdx=0, restarting the sweep even mid-sweep.
REQ-026 While rst=1, and throughout the sweep, ready SHALL be 0, hit SHALL be 0, and predictedNextPc SHALL be lookupPc+4.
REQ-027 After rst deasserts, ready SHALL rise exactly ENTRIES cycles later.
REQ-028 Reset SHALL not be required to clear tag, target, or counter storage; valid=0 masks them.

Structure
REQ-029 SHALL place the PC type, BTB_ENTRIES default, the BtbEntry struct (valid, tag, target, counter) and the BtbState enum in the shared PipelineTypes package.
REQ-030 SHALL implement the saturating counter update as a package function; no sub-module is needed.
REQ-031 SHALL use flop-based storage with a single write port and a single combinational read port.

Verification
REQ-032 Reset sweep: rst high 1 cycle -> ready=0 for 64 cycles, ready=1 on cycle 65; lookupPc=0x100 -> hit=0, predictedNextPc=0x104.
REQ-033 Allocate and predict: update pc=0x100, taken, target=0x200 -> next cycle lookupPc=0x100 gives hit=1, predictedNextPc=0x200.
REQ-034 Hysteresis: from counter 2'b10, send one not-taken update -> hit=0; a second not-taken gives counter 2'b00; one taken gives 2'b01 (hit=0); a second taken gives hit=1.
REQ-035 Alias: entry at 0x100; lookupPc=0x200 (same index, different tag) -> hit=0; a taken update at 0x200 replaces the entry -> lookupPc=0x100 gives hit=0.
REQ-036 Same-cycle update and lookup at 0x100 (target 0x300, entry absent) -> hit=0 that cycle, hit=1 with predictedNextPc=0x300 next cycle.
REQ-037 rst at sweep cycle 30 -> ready stays 0 for a further 64 cycles; updates issued during the sweep leave no entries.

Source files
------------

// File: rtl/branch_target_buffer_pkg.sv
// Shared pipeline types for the branch target buffer: PC type, entry
// layout, controller states and the 2-bit saturating counter update.
package PipelineTypes;

    localparam int PC_BITS     = 32;
    localparam int BTB_ENTRIES = 64;

    typedef logic [PC_BITS-1:0] pc_t;

    // Tag is held zero-extended in a full PC-sized field so one struct
    // serves every ENTRIES setting.
    typedef struct packed {
        logic       valid;
        pc_t        tag;
        pc_t        target;
        logic [1:0] counter;
    } BtbEntry;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } BtbState;

    // Two-bit saturating counter: step up on taken, down on not-taken.
    function automatic logic [1:0] sat_counter_update(input logic [1:0] ctr,
                                                      input logic       taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer. Lookup is purely combinational from
// the stored entries; resolved branches train the table one per cycle.
// After reset an invalidation sweep clears one valid bit per cycle.
module branch_target_buffer
    import PipelineTypes::*;
#(
    parameter int ENTRIES  = BTB_ENTRIES,
    parameter int PC_WIDTH = PC_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] lookupPc,
    output logic                hit,
    output logic [PC_WIDTH-1:0] predictedNextPc,
    output logic                ready,
    input  logic                updValid,
    input  logic [PC_WIDTH-1:0] updPc,
    input  logic                updTaken,
    input  logic [PC_WIDTH-1:0] updTarget
);

    localparam int IDX = $clog2(ENTRIES);

    BtbState        state_q, state_d;
    logic [IDX-1:0] sweep_q, sweep_d;
    BtbEntry        entries_q [ENTRIES];

    logic [IDX-1:0] lk_idx_s, up_idx_s, wr_idx_s;
    pc_t            lk_tag_s, up_tag_s;
    BtbEntry        lk_entry_s, up_entry_s, wr_entry_s;
    logic           lk_match_s, up_match_s, wr_en_s, ready_s;
    logic           pc_lo_unused;

    // Byte offset of the update PC never takes part in indexing or tagging.
    assign pc_lo_unused = ^updPc[1:0];

    // Split both PCs into index and tag, read the addressed entries.
    always_comb begin
        lk_idx_s   = lookupPc[IDX+1:2];
        lk_tag_s   = pc_t'(lookupPc[PC_WIDTH-1:IDX+2]);
        up_idx_s   = updPc[IDX+1:2];
        up_tag_s   = pc_t'(updPc[PC_WIDTH-1:IDX+2]);
        lk_entry_s = entries_q[lk_idx_s];
        up_entry_s = entries_q[up_idx_s];
        lk_match_s = lk_entry_s.valid && (lk_entry_s.tag == lk_tag_s);
        up_match_s = up_entry_s.valid && (up_entry_s.tag == up_tag_s);
    end

    // Prediction outputs; table state is pre-edge so there is no update bypass.
    always_comb begin
        ready_s = (state_q == RUN) && !rst;
        ready   = ready_s;
        hit     = ready_s && lk_match_s && lk_entry_s.counter[1];
        if (hit) begin
            predictedNextPc = lk_entry_s.target[PC_WIDTH-1:0];
        end else begin
            predictedNextPc = lookupPc + PC_WIDTH'(4);
        end
    end

    // Controller: sweep invalidation in INIT, branch training in RUN.
    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        wr_en_s    = 1'b0;
        wr_idx_s   = up_idx_s;
        wr_entry_s = up_entry_s;
        case (state_q)
            INIT: begin
                wr_en_s    = 1'b1;
                wr_idx_s   = sweep_q;
                wr_entry_s = '{valid: 1'b0, tag: '0, target: '0, counter: 2'b00};
                sweep_d    = sweep_q + IDX'(1);
                if (sweep_q == IDX'(ENTRIES - 1)) begin
                    state_d = RUN;
                end else begin
                    state_d = INIT;
                end
            end
            RUN: begin
                if (updValid && up_match_s) begin
                    wr_en_s            = 1'b1;
                    wr_entry_s.counter = sat_counter_update(up_entry_s.counter, updTaken);
                    if (updTaken) begin
                        wr_entry_s.target = pc_t'(updTarget);
                    end else begin
                        wr_entry_s.target = up_entry_s.target;
                    end
                end else if (updValid && updTaken) begin
                    wr_en_s    = 1'b1;
                    wr_entry_s = '{valid: 1'b1, tag: up_tag_s,
                                   target: pc_t'(updTarget), counter: 2'b10};
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            default: begin
                state_d = INIT;
                sweep_d = {IDX{1'b0}};
            end
        endcase
    end

    // Controller state registers; reset restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            sweep_q <= {IDX{1'b0}};
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Single write port into the flop table; payload is never reset.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            entries_q[wr_idx_s] <= wr_entry_s;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: each cycle's stimulus pushes
// its hand-computed expectation into a queue; a negedge monitor pops and
// compares it against the combinational outputs.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookupPc;
    logic        hit;
    logic [31:0] predictedNextPc;
    logic        ready;
    logic        updValid;
    logic [31:0] updPc;
    logic        updTaken;
    logic [31:0] updTarget;

    typedef struct {
        string       name;
        logic        rdy;
        logic        hit;
        logic [31:0] npc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    branch_target_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .lookupPc       (lookupPc),
        .hit            (hit),
        .predictedNextPc(predictedNextPc),
        .ready          (ready),
        .updValid       (updValid),
        .updPc          (updPc),
        .updTaken       (updTaken),
        .updTarget      (updTarget)
    );

    always #5 clk = ~clk;

    // Monitor: compare outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors = vectors + 1;
            if (ready !== e.rdy || hit !== e.hit || predictedNextPc !== e.npc) begin
                miscompares = miscompares + 1;
                $display("FAIL %s: got ready=%0b hit=%0b npc=%h, want ready=%0b hit=%0b npc=%h",
                         e.name, ready, hit, predictedNextPc, e.rdy, e.hit, e.npc);
            end
        end
    end

    // Queue the expectation for the inputs currently applied, then advance.
    task automatic cyc(input string nm, input logic er, input logic eh,
                       input logic [31:0] enp);
        exp_t e;
        e.name = nm;
        e.rdy  = er;
        e.hit  = eh;
        e.npc  = enp;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic v, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt);
        updValid  = v;
        updPc     = pc;
        updTaken  = tk;
        updTarget = tgt;
    endtask

    initial begin
        rst      = 1'b1;
        lookupPc = 32'h0000_0100;
        upd(1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        cyc("rst_hold", 1'b0, 1'b0, 32'h0000_0104);
        rst = 1'b0;

        // Partial sweep, then reset again at sweep cycle 30.
        for (int k = 1; k <= 30; k++) cyc("sweep_a", 1'b0, 1'b0, 32'h0000_0104);
        rst = 1'b1;
        cyc("rst_mid", 1'b0, 1'b0, 32'h0000_0104);
        rst = 1'b0;

        // Full sweep; updates issued during it must be dropped.
        for (int k = 1; k <= 64; k++) begin
            if (k == 50)      upd(1'b1, 32'h0000_0000, 1'b1, 32'h0000_0700);
            else if (k == 60) upd(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0500);
            else              upd(1'b0, 32'h0, 1'b0, 32'h0);
            cyc("sweep_b", 1'b0, 1'b0, 32'h0000_0104);
        end
        upd(1'b0, 32'h0, 1'b0, 32'h0);
        cyc("ready_rise", 1'b1, 1'b0, 32'h0000_0104);
        lookupPc = 32'h0000_0000;
        cyc("no_entry_idx0", 1'b1, 1'b0, 32'h0000_0004);

        // Allocate at 0x100 -> 0x200, counter 10.
        lookupPc = 32'h0000_0100;
        upd(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200);
        cyc("alloc_same_cyc", 1'b1, 1'b0, 32'h0000_0104);
        upd(1'b0, 32'h0, 1'b0, 32'h0);
        cyc("alloc_predict", 1'b1, 1'b1, 32'h0000_0200);

        // Hysteresis 10 -> 01 -> 00 -> 01 -> 10.
        upd(1'b1, 32'h0000_0100, 1'b0, 32'h0);
        cyc("nt1_pre", 1'b1, 1'b1, 32'h0000_0200);
        upd(1'b0, 32'h0, 1'b0, 32'h0);
        cyc("ctr01", 1'b1, 1'b0, 32'h0000_0104);
        upd(1'b1, 32'h0000_0100, 1'b0, 32'h0);
        cyc("nt2", 1'b1, 1'b0, 32'h0000_0104);
        upd(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200);
        cyc("tk1", 1'b1, 1'b0, 32'h0000_0104);
        upd(1'b0, 32'h0, 1'b0, 32'h0);
        cyc("ctr01_again", 1'b1, 1'b0, 32'h0000_0104);
        upd(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200);
        cyc("tk2", 1'b1, 1'b0, 32'h0000_0104);
        upd(1'b0, 32'h0, 1'b0, 32'h0);
        cyc("ctr10", 1'b1, 1'b1, 32'h0000_0200);

        // Upper saturation: 10 -> 11 -> 11 (new target), then 11 -> 10.
        upd(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200);
        cyc("tk_to11", 1'b1, 1'b1, 32'h0000_0200);
        upd(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0240);
        cyc("tk_sat11", 1'b1, 1'b1, 32'h0000_0200);
        upd(1'b1, 32'h0000_0100, 1'b0, 32'h0);
        cyc("nt_from11", 1'b1, 1'b1, 32'h0000_0240);
        upd(1'b0, 32'h0, 1'b0, 32'h0);
        cyc("sat_hi_hold", 1'b1, 1'b1, 32'h0000_0240);

        // Lower saturation: 10 -> 01 -> 00 -> 00.
        upd(1'b1, 32'h0000_0100, 1'b0, 32'h0);
        cyc("nt_a", 1'b1, 1'b1, 32'h0000_0240);
        cyc("nt_b", 1'b1, 1'b0, 32'h0000_0104);
        cyc("nt_c", 1'b1, 1'b0, 32'h0000_0104);
        upd(1'b0, 32'h0, 1'b0, 32'h0);
        cyc("sat_lo_hold", 1'b1, 1'b0, 32'h0000_0104);

        // Back to 10, then alias at 0x200 (same index, other tag).
        upd(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200);
        cyc("retrain_a", 1'b1, 1'b0, 32'h0000_0104);
        cyc("retrain_b", 1'b1, 1'b0, 32'h0000_0104);
        upd(1'b0, 32'h0, 1'b0, 32'h0);
        cyc("retrained", 1'b1, 1'b1, 32'h0000_0200);
        lookupPc = 32'h0000_0200;
        cyc("alias_miss", 1'b1, 1'b0, 32'h0000_0204);
        upd(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0800);
        cyc("alias_repl_same", 1'b1, 1'b0, 32'h0000_0204);
        upd(1'b0, 32'h0, 1'b0, 32'h0);
        cyc("alias_new_hit", 1'b1, 1'b1, 32'h0000_0800);
        lookupPc = 32'h0000_0100;
        cyc("alias_old_gone", 1'b1, 1'b0, 32'h0000_0104);

        // Not-taken miss must not disturb the resident 0x200 entry.
        upd(1'b1, 32'h0000_0100, 1'b0, 32'h0);
        cyc("nt_miss", 1'b1, 1'b0, 32'h0000_0104);
        upd(1'b0, 32'h0, 1'b0, 32'h0);
        lookupPc = 32'h0000_0200;
        cyc("nt_miss_nochg", 1'b1, 1'b1, 32'h0000_0800);

        // updValid=0 ignores other update inputs.
        upd(1'b0, 32'h0000_0104, 1'b1, 32'h0000_0900);
        lookupPc = 32'h0000_0104;
        cyc("updv0_a", 1'b1, 1'b0, 32'h0000_0108);
        cyc("updv0_b", 1'b1, 1'b0, 32'h0000_0108);

        // Same-cycle update and lookup at absent 0x100.
        upd(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0300);
        lookupPc = 32'h0000_0100;
        cyc("same_cyc_pre", 1'b1, 1'b0, 32'h0000_0104);
        upd(1'b0, 32'h0, 1'b0, 32'h0);
        cyc("same_cyc_post", 1'b1, 1'b1, 32'h0000_0300);
        lookupPc = 32'h0000_0103;
        cyc("low_bits_ignored", 1'b1, 1'b1, 32'h0000_0300);

        // Another index, and +4 wrap at the top of the address space.
        upd(1'b1, 32'h0000_001C, 1'b1, 32'h0000_0ABC);
        lookupPc = 32'h0000_001C;
        cyc("idx7_pre", 1'b1, 1'b0, 32'h0000_0020);
        upd(1'b0, 32'h0, 1'b0, 32'h0);
        cyc("idx7_hit", 1'b1, 1'b1, 32'h0000_0ABC);
        lookupPc = 32'hFFFF_FFFC;
        cyc("wrap", 1'b1, 1'b0, 32'h0000_0000);

        // Reset from RUN clears the table after a full sweep.
        lookupPc = 32'h0000_0100;
        rst = 1'b1;
        cyc("rst_run", 1'b0, 1'b0, 32'h0000_0104);
        rst = 1'b0;
        for (int k = 1; k <= 64; k++) cyc("sweep_c", 1'b0, 1'b0, 32'h0000_0104);
        cyc("ready_rise2", 1'b1, 1'b0, 32'h0000_0104);
        lookupPc = 32'h0000_001C;
        cyc("cleared_idx7", 1'b1, 1'b0, 32'h0000_0020);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            miscompares = miscompares + 1;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
